// File: rtl/imem_fetch.sv
// imem_fetch: instruction fetch stage with a wait-stated ROM access and a one-entry line buffer
module imem_fetch #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock_i,
    input  logic                  nreset_i,
    input  logic [ADDR_WIDTH-1:0] ctrl_addr_i,
    input  logic                  ctrl_CEn_i,
    input  logic                  ctrl_OEn_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] im_data_o,
    output logic                  hold_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  rom_CEn_o,
    output logic                  rom_OEn_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i
);
    localparam int CW = ($clog2(WAIT_STATES + 1) > 1) ? $clog2(WAIT_STATES + 1) : 1;
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_n;
    logic valid, valid_n, discard, discard_n, rom_off, rom_off_n;
    logic [ADDR_WIDTH-1:0] tag, tag_n, addr_q, addr_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic [CW-1:0] count, count_n;
    logic req, hit, miss;
    assign req = !ctrl_CEn_i && !ctrl_OEn_i;
    assign hit = valid && (tag == ctrl_addr_i);
    assign miss = req && !hit;
    assign hold_o = nreset_i && ((state == ACCESS) || (state == IDLE && miss));
    assign im_data_o = data_q;
    assign rom_addr_o = addr_q;
    assign rom_CEn_o = rom_off;
    assign rom_OEn_o = rom_off;
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state   <= IDLE;
            valid   <= 1'b0;
            discard <= 1'b0;
            rom_off <= 1'b1;
            tag     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count   <= '0;
        end else begin
            state   <= state_n;
            valid   <= valid_n;
            discard <= discard_n;
            rom_off <= rom_off_n;
            tag     <= tag_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            count   <= count_n;
        end
    end
    always_comb begin
        state_n   = state;
        valid_n   = valid;
        discard_n = discard;
        rom_off_n = rom_off;
        tag_n     = tag;
        addr_n    = addr_q;
        data_n    = data_q;
        count_n   = count;
        if (state == IDLE) begin
            if (flush_i) begin
                valid_n = 1'b0;
            end else if (miss) begin
                addr_n    = ctrl_addr_i;
                rom_off_n = 1'b0;
                count_n   = CW'(WAIT_STATES);
                discard_n = 1'b0;
                state_n   = ACCESS;
            end
        end else begin
            discard_n = discard || flush_i;
            if (count != '0) begin
                count_n = count - CW'(1);
            end else begin
                // a flush seen anywhere in the access, including this last cycle, discards the fill
                data_n    = rom_data_i;
                tag_n     = addr_q;
                valid_n   = !(discard || flush_i);
                rom_off_n = 1'b1;
                state_n   = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: scoreboard bench for imem_fetch, one instance with two wait states and one with none
module tb_imem_fetch;
    localparam int WA = 2;
    localparam int WB = 0;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic nreset, cen, oen, flush, sel;
    logic [9:0] addr, raddr_a, raddr_b, raddr_s;
    logic [15:0] data_a, data_b, data_s, rdata_a, rdata_b;
    logic hold_a, hold_b, hold_s, rcen_a, rcen_b, rcen_s, roen_a, roen_b;
    logic [15:0] rom [1024];
    logic [15:0] exp_q [$];
    int hold_q [$];
    int checks = 0;
    int failures = 0;
    assign rdata_a = rom[raddr_a];
    assign rdata_b = rom[raddr_b];
    assign hold_s = sel ? hold_b : hold_a;
    assign data_s = sel ? data_b : data_a;
    assign rcen_s = sel ? rcen_b : rcen_a;
    assign raddr_s = sel ? raddr_b : raddr_a;
    imem_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .WAIT_STATES(WA)) dut_a (
        .clock_i(clk), .nreset_i(nreset), .ctrl_addr_i(addr), .ctrl_CEn_i(cen), .ctrl_OEn_i(oen),
        .flush_i(flush), .im_data_o(data_a), .hold_o(hold_a), .rom_addr_o(raddr_a),
        .rom_CEn_o(rcen_a), .rom_OEn_o(roen_a), .rom_data_i(rdata_a));
    imem_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .WAIT_STATES(WB)) dut_b (
        .clock_i(clk), .nreset_i(nreset), .ctrl_addr_i(addr), .ctrl_CEn_i(cen), .ctrl_OEn_i(oen),
        .flush_i(flush), .im_data_o(data_b), .hold_o(hold_b), .rom_addr_o(raddr_b),
        .rom_CEn_o(rcen_b), .rom_OEn_o(roen_b), .rom_data_i(rdata_b));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic run(input logic s, input logic [9:0] a, input logic [9:0] a2, input int sw_at,
                       input int fl_at, input int exp_hold, input int exp_cen);
        int n;
        int cl;
        logic [9:0] fa;
        fa = (sw_at >= 0) ? a2 : a;
        exp_q.push_back(rom[fa]);
        hold_q.push_back(exp_hold);
        sel = s;
        @(negedge clk);
        addr = a;
        cen = 1'b0;
        oen = 1'b0;
        flush = 1'b0;
        #1;
        n = 0;
        cl = 0;
        while (hold_s && n < 64) begin
            if (!rcen_s) cl++;
            n++;
            @(negedge clk);
            if (n == sw_at) addr = a2;
            flush = (n == fl_at);
            #1;
        end
        flush = 1'b0;
        check("hold_cycles", n, hold_q.pop_front());
        check("im_data", data_s, exp_q.pop_front());
        check("rom_cen_cycles", cl, exp_cen);
        if (exp_cen > 0) check("rom_addr", raddr_s, fa);
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 16'(i * 40503 + 7);
        rom[0] = 16'h8005;
        sel = 1'b0;
        nreset = 1'b0;
        addr = '0;
        cen = 1'b0;
        oen = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold", hold_a, 0);
        check("rst_data", data_a, 0);
        check("rst_cen", rcen_a, 1);
        check("rst_oen", roen_a, 1);
        check("rst_addr", raddr_a, 0);
        cen = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        run(0, 10'h000, 0, -1, -1, WA + 2, WA + 1);
        run(0, 10'h000, 0, -1, -1, 0, 0);
        rom[10'h3FF] = 16'h1234;
        rom[10'h000] = 16'h5678;
        run(0, 10'h3FF, 0, -1, -1, WA + 2, WA + 1);
        run(0, 10'h000, 0, -1, -1, WA + 2, WA + 1);
        run(0, 10'h010, 10'h020, 1, -1, 2 * (WA + 2), 2 * (WA + 1));
        run(0, 10'h005, 0, -1, 2, 2 * (WA + 2), 2 * (WA + 1));
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_idle_hit", hold_a, 0);
        run(0, 10'h005, 0, -1, -1, WA + 2, WA + 1);
        @(negedge clk);
        addr = 10'h0AB;
        #1;
        check("rst_pre_miss", hold_a, 1);
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_access", rcen_a, 0);
        nreset = 1'b0;
        #1;
        check("rst_abort_cen", rcen_a, 1);
        check("rst_abort_hold", hold_a, 0);
        cen = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        run(0, 10'h0AB, 0, -1, -1, WA + 2, WA + 1);
        nreset = 1'b0;
        cen = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        run(1, 10'h100, 0, -1, -1, WB + 2, WB + 1);
        run(1, 10'h101, 0, -1, -1, WB + 2, WB + 1);
        run(1, 10'h101, 0, -1, -1, 0, 0);
        run(1, 10'h102, 0, -1, 1, 2 * (WB + 2), 2 * (WB + 1));
        @(negedge clk);
        addr = 10'h103;
        #1;
        check("b_pre_miss", hold_b, 1);
        @(negedge clk);
        #1;
        check("b_in_access", rcen_b, 0);
        nreset = 1'b0;
        #1;
        check("b_abort_cen", rcen_b, 1);
        check("b_abort_hold", hold_b, 0);
        cen = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        run(1, 10'h103, 0, -1, -1, WB + 2, WB + 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
Instruction-fetch stage between the instruction ROM and the processor control unit. It takes the control unit's ROM address and enables, runs a multi-cycle ROM access with a fixed wait-state count, and holds the last fetched word in a one-entry line buffer. It stalls the control unit through its hold input until a valid instruction for the requested address is present. A flush input invalidates the buffer after self-modifying or external ROM reload events.

Parameters:
DATA_WIDTH, 16, instruction word width
ADDR_WIDTH, 10, instruction address width
WAIT_STATES, 2, extra ROM cycles per access (0 allowed); counter width = max(1, clog2(WAIT_STATES+1))

Ports:
clock_i  input  1  system clock, rising edge
nreset_i  input  1  asynchronous reset, active low
ctrl_addr_i  input  ADDR_WIDTH  fetch address from control (PC)
ctrl_CEn_i  input  1  control chip enable, active low
ctrl_OEn_i  input  1  control output enable, active low
flush_i  input  1  invalidate line buffer, active high, synchronous
im_data_o  output  DATA_WIDTH  instruction word to control
hold_o  output  1  stall to control hold input, active high
rom_addr_o  output  ADDR_WIDTH  ROM address
rom_CEn_o  output  1  ROM chip enable, active low
rom_OEn_o  output  1  ROM output enable, active low
rom_data_i  input  DATA_WIDTH  ROM read data

Behaviour:
- Reset (async, nreset_i low): state=IDLE, valid=0, tag=0, data_q=0, count=0, rom_addr_o=0, rom_CEn_o=1, rom_OEn_o=1, im_data_o=0. hold_o forced 0 while nreset_i low. Reset mid-ACCESS aborts the access and leaves the buffer invalid.
- req = !ctrl_CEn_i & !ctrl_OEn_i. hit = valid & (tag == ctrl_addr_i). miss = req & !hit.
- hold_o (combinational) = (state==ACCESS) | (state==IDLE & miss). No request means hold_o=0.
- im_data_o = data_q at all times (registered, glitch-free).
- FSM IDLE: on a clock edge with miss and no flush_i, latch ctrl_addr_i into rom_addr_o, set rom_CEn_o=0 and rom_OEn_o=0, load count=WAIT_STATES, go to ACCESS. On a hit, stay in IDLE.
- FSM ACCESS: when count>0, decrement. When count==0, capture rom_data_i into data_q and rom_addr_o into tag, set valid=1 (unless the fill is discarded), set rom_CEn_o=1 and rom_OEn_o=1, go to IDLE.
- ACCESS duration is WAIT_STATES+1 cycles. hold_o for a miss lasts WAIT_STATES+2 cycles: the detect cycle plus ACCESS. hold_o drops the cycle after capture, and the hit presents the new data_q.
- ctrl_addr_i changes during ACCESS are ignored. The access completes for the latched address. The next IDLE compare then misses and starts a new access.
- ctrl_CEn_i or ctrl_OEn_i deasserting during ACCESS does not abort the access. The fill completes normally.
- flush_i in IDLE clears valid at the next edge. No access starts that cycle, even if miss.
- flush_i during ACCESS marks the fill discarded. data_q and tag still update, valid stays 0, and the next request re-fetches.
- Address wrap: 10-bit address 0x3FF is an ordinary address. No arithmetic is done on addresses; the PC increment belongs to control.
- rom_CEn_o and rom_OEn_o are registered. They are low exactly during ACCESS cycles.

Test Plan:
- Cold miss: after reset, with WAIT_STATES=2, ctrl_addr_i=0x000, ROM[0]=0x8005, req held -> hold_o high 4 cycles, rom_CEn_o low 3 cycles, then hold_o=0 and im_data_o=0x8005.
- Hit: with the buffer holding 0x000, re-request 0x000 -> hold_o stays 0, rom_CEn_o stays 1, im_data_o=0x8005.
- Sequential: request 0x3FF then 0x000 (ROM=0x1234, 0x5678) -> two full misses, im_data_o goes 0x1234 then 0x5678, rom_addr_o=0x3FF then 0x000.
- Address change mid-access: start 0x010, switch to 0x020 during ACCESS -> rom_addr_o stays 0x010 until done, then a second access to 0x020; final im_data_o=ROM[0x020], hold_o high throughout.
- Flush: flush_i pulse in cycle 2 of ACCESS for 0x005 -> valid=0 after the fill, immediate re-fetch of 0x005, 4 more hold cycles. flush_i in IDLE on a hit -> next cycle misses.
- Reset mid-access: nreset_i low in ACCESS -> rom_CEn_o=1 and hold_o=0 immediately. After release, the same request produces a full miss. Repeat with WAIT_STATES=0: 2-cycle hold per miss.
